// File: rtl/pixel_depth_writer.sv
// Pixel sink with z-buffer test.
// Clears the depth RAM and the framebuffer, accepts pixels over valid/ready,
// compares each pixel's depth against the stored depth and forwards winning
// pixels to the framebuffer write port. The last pixel of a frame triggers a
// frame_done pulse followed by a new clear sweep.
module pixel_depth_writer #(
   parameter int                     BUFFER_WIDTH  = 160,
   parameter int                     BUFFER_HEIGHT = 120,
   parameter int                     DEPTH_WIDTH   = 16,
   parameter int                     COLOR_WIDTH   = 12,
   parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR   = '0,
   parameter int                     ADDR_WIDTH    = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pixel_data_s_valid,
   output logic                   pixel_data_s_ready,
   input  logic [7:0]             pixel_data_s_x,
   input  logic [6:0]             pixel_data_s_y,
   input  logic [DEPTH_WIDTH-1:0] pixel_data_s_depth,
   input  logic [COLOR_WIDTH-1:0] pixel_data_s_color,
   input  logic                   pixel_data_s_last,
   output logic                   fb_write_en,
   output logic [ADDR_WIDTH-1:0]  fb_write_addr,
   output logic [COLOR_WIDTH-1:0] fb_write_data,
   output logic                   clearing,
   output logic                   frame_done
);

   localparam int                    NUM_PIXELS = BUFFER_WIDTH * BUFFER_HEIGHT;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_PIXELS - 1);
   localparam logic [31:0]           WIDTH_U    = 32'(BUFFER_WIDTH);
   localparam logic [31:0]           HEIGHT_U   = 32'(BUFFER_HEIGHT);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_ACCEPT,
      S_TEST,
      S_LAST
   } state_t;

   state_t                   state_reg;
   state_t                   state_next;

   logic [ADDR_WIDTH-1:0]    cnt_reg;

   // Latched pixel (captured on the accepting cycle)
   logic [ADDR_WIDTH-1:0]    px_addr_reg;
   logic [DEPTH_WIDTH-1:0]   px_depth_reg;
   logic [COLOR_WIDTH-1:0]   px_color_reg;
   logic                     px_last_reg;
   logic                     px_in_range_reg;

   // Registered winning-pixel write, presented one cycle after the test
   logic                     wr_en_reg;
   logic [ADDR_WIDTH-1:0]    wr_addr_reg;
   logic [COLOR_WIDTH-1:0]   wr_data_reg;

   // Depth RAM with registered read
   logic [DEPTH_WIDTH-1:0]   depth_mem [NUM_PIXELS];
   logic [DEPTH_WIDTH-1:0]   rd_data_reg;

   logic                     transfer;
   logic                     in_range_in;
   logic [ADDR_WIDTH-1:0]    addr_calc;
   logic                     win_test;

   assign transfer    = pixel_data_s_valid && (state_reg == S_ACCEPT);
   assign in_range_in = (32'(pixel_data_s_x) < WIDTH_U) && (32'(pixel_data_s_y) < HEIGHT_U);
   assign addr_calc   = ADDR_WIDTH'(pixel_data_s_y) * ADDR_WIDTH'(BUFFER_WIDTH)
                      + ADDR_WIDTH'(pixel_data_s_x);
   // Strictly nearer pixels win; equal depth keeps the stored pixel
   assign win_test    = px_in_range_reg && (px_depth_reg < rd_data_reg);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_CLEAR;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and output decode; the clear sweep owns the fb port
   always_comb begin
      state_next         = state_reg;
      pixel_data_s_ready = 1'b0;
      clearing           = 1'b0;
      frame_done         = 1'b0;
      fb_write_en        = wr_en_reg;
      fb_write_addr      = wr_addr_reg;
      fb_write_data      = wr_data_reg;
      case (state_reg)
         S_CLEAR: begin
            clearing      = 1'b1;
            fb_write_en   = 1'b1;
            fb_write_addr = cnt_reg;
            fb_write_data = CLEAR_COLOR;
            if (cnt_reg == LAST_ADDR) begin
               state_next = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            pixel_data_s_ready = 1'b1;
            if (pixel_data_s_valid) begin
               state_next = S_TEST;
            end
         end
         S_TEST: begin
            state_next = px_last_reg ? S_LAST : S_ACCEPT;
         end
         S_LAST: begin
            frame_done = 1'b1;
            state_next = S_CLEAR;
         end
         default: begin
            state_next = S_CLEAR;
         end
      endcase
   end

   // Clear counter and the registered winning-pixel write
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg     <= '0;
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         if (state_reg == S_CLEAR) begin
            cnt_reg <= (cnt_reg == LAST_ADDR) ? '0 : cnt_reg + 1'b1;
         end else begin
            cnt_reg <= '0;
         end
         wr_en_reg <= (state_reg == S_TEST) && win_test;
         if ((state_reg == S_TEST) && win_test) begin
            wr_addr_reg <= px_addr_reg;
            wr_data_reg <= px_color_reg;
         end
      end
   end

   // Capture the accepted pixel
   always_ff @(posedge clk) begin
      if (transfer) begin
         px_addr_reg     <= addr_calc;
         px_depth_reg    <= pixel_data_s_depth;
         px_color_reg    <= pixel_data_s_color;
         px_last_reg     <= pixel_data_s_last;
         px_in_range_reg <= in_range_in;
      end
   end

   // Depth RAM write port: clear sweep or winning pixel, suppressed under reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_reg == S_CLEAR) begin
            depth_mem[cnt_reg] <= '1;
         end else if ((state_reg == S_TEST) && win_test) begin
            depth_mem[px_addr_reg] <= px_depth_reg;
         end
      end
   end

   // Depth RAM read port: issued on the accepting cycle for in-range pixels only
   always_ff @(posedge clk) begin
      if (transfer && in_range_in) begin
         rd_data_reg <= depth_mem[addr_calc];
      end
   end

endmodule

// File: tb/tb_pixel_depth_writer.sv
// Directed testbench for pixel_depth_writer: clear sweep, z-test ordering,
// out-of-range pixels, frame end, and reset in the middle of operation.
module tb_pixel_depth_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pixel_data_s_valid = 1'b0;
   logic        pixel_data_s_ready;
   logic [7:0]  pixel_data_s_x = '0;
   logic [6:0]  pixel_data_s_y = '0;
   logic [15:0] pixel_data_s_depth = '0;
   logic [11:0] pixel_data_s_color = '0;
   logic        pixel_data_s_last = 1'b0;
   logic        fb_write_en;
   logic [14:0] fb_write_addr;
   logic [11:0] fb_write_data;
   logic        clearing;
   logic        frame_done;

   int vectors     = 0;
   int miscompares = 0;

   pixel_depth_writer dut (
      .clk                (clk),
      .rst                (rst),
      .pixel_data_s_valid (pixel_data_s_valid),
      .pixel_data_s_ready (pixel_data_s_ready),
      .pixel_data_s_x     (pixel_data_s_x),
      .pixel_data_s_y     (pixel_data_s_y),
      .pixel_data_s_depth (pixel_data_s_depth),
      .pixel_data_s_color (pixel_data_s_color),
      .pixel_data_s_last  (pixel_data_s_last),
      .fb_write_en        (fb_write_en),
      .fb_write_addr      (fb_write_addr),
      .fb_write_data      (fb_write_data),
      .clearing           (clearing),
      .frame_done         (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Called at a negedge; the following posedge samples rst=1
   task automatic apply_reset();
      rst = 1'b1;
      pixel_data_s_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at the negedge of clear cycle 0; returns at the first ACCEPT negedge.
   // With hold=1 a winning pixel is offered throughout the sweep.
   task automatic run_clear(input string tag, input logic hold);
      int cycles   = 0;
      int writes   = 0;
      int bad_addr = 0;
      int bad_data = 0;
      int bad_ctl  = 0;
      check({tag, "_first_addr"}, fb_write_addr, 0);
      check({tag, "_first_done"}, frame_done, 0);
      pixel_data_s_x     = 8'd5;
      pixel_data_s_y     = 7'd5;
      pixel_data_s_depth = 16'h0100;
      pixel_data_s_color = 12'hABC;
      pixel_data_s_last  = 1'b0;
      pixel_data_s_valid = hold;
      while (clearing === 1'b1 && cycles < 20000) begin
         if (fb_write_en === 1'b1) begin
            if (32'(fb_write_addr) != cycles) bad_addr++;
            writes++;
         end
         if (fb_write_data !== 12'h000) bad_data++;
         if (pixel_data_s_ready !== 1'b0 || frame_done !== 1'b0 || fb_write_en !== 1'b1) bad_ctl++;
         cycles++;
         @(negedge clk);
      end
      pixel_data_s_valid = 1'b0;
      check({tag, "_cycles"}, cycles, 19200);
      check({tag, "_writes"}, writes, 19200);
      check({tag, "_bad_addr"}, bad_addr, 0);
      check({tag, "_bad_data"}, bad_data, 0);
      check({tag, "_bad_ctl"}, bad_ctl, 0);
      check({tag, "_after_rdy"}, pixel_data_s_ready, 1);
      check({tag, "_after_we"}, fb_write_en, 0);
   endtask

   // Called at an ACCEPT negedge (cycle T); returns at the negedge of T+2
   task automatic send_pixel(input string tag, input logic [7:0] x, input logic [6:0] y,
                             input logic [15:0] d, input logic [11:0] c, input logic last,
                             input logic exp_wr, input logic [14:0] exp_addr,
                             input logic [11:0] exp_data);
      check({tag, "_t0_rdy"}, pixel_data_s_ready, 1);
      pixel_data_s_x     = x;
      pixel_data_s_y     = y;
      pixel_data_s_depth = d;
      pixel_data_s_color = c;
      pixel_data_s_last  = last;
      pixel_data_s_valid = 1'b1;
      @(negedge clk);
      pixel_data_s_valid = 1'b0;
      check({tag, "_t1_rdy"}, pixel_data_s_ready, 0);
      check({tag, "_t1_we"}, fb_write_en, 0);
      @(negedge clk);
      check({tag, "_t2_we"}, fb_write_en, exp_wr);
      if (exp_wr) begin
         check({tag, "_t2_addr"}, fb_write_addr, exp_addr);
         check({tag, "_t2_data"}, fb_write_data, exp_data);
      end
      check({tag, "_t2_done"}, frame_done, last);
      check({tag, "_t2_rdy"}, pixel_data_s_ready, !last);
   endtask

   initial begin
      int cycles;

      // Power-up reset and first clear; a held valid must not be consumed
      apply_reset();
      check("rst_clearing", clearing, 1);
      check("rst_ready", pixel_data_s_ready, 0);
      run_clear("clr0", 1'b1);

      // First write, then z-test ordering at the same location
      send_pixel("px_first", 8'd3, 7'd2, 16'h1000, 12'hF00, 1'b0, 1'b1, 15'd323, 12'hF00);
      send_pixel("px_far",   8'd3, 7'd2, 16'h2000, 12'h00F, 1'b0, 1'b0, 15'd0, 12'h000);
      send_pixel("px_equal", 8'd3, 7'd2, 16'h1000, 12'h00F, 1'b0, 1'b0, 15'd0, 12'h000);
      send_pixel("px_near",  8'd3, 7'd2, 16'h0800, 12'h0F0, 1'b0, 1'b1, 15'd323, 12'h0F0);

      // Held pixel (depth 0100) was not consumed, so depth 0200 still wins here
      send_pixel("px_held",  8'd5, 7'd5, 16'h0200, 12'h123, 1'b0, 1'b1, 15'd805, 12'h123);

      // Out-of-range pixels; the second one ends the frame
      send_pixel("oor_x",    8'd160, 7'd0, 16'h0001, 12'hFFF, 1'b0, 1'b0, 15'd0, 12'h000);
      send_pixel("oor_last", 8'd0, 7'd120, 16'h0001, 12'hFFF, 1'b1, 1'b0, 15'd0, 12'h000);

      // Clear starts; reset it when the counter reaches 500
      @(negedge clk);
      check("clr_mid_clearing", clearing, 1);
      cycles = 0;
      while (fb_write_addr !== 15'd500 && cycles < 1000) begin
         cycles++;
         @(negedge clk);
      end
      check("clr_mid_addr", fb_write_addr, 500);
      apply_reset();
      run_clear("clr1", 1'b0);

      // Last pixel writes and ends the frame; depth is reset by the clear
      send_pixel("last_px",  8'd0, 7'd0, 16'hFFFE, 12'h456, 1'b1, 1'b1, 15'd0, 12'h456);
      @(negedge clk);
      run_clear("clr2", 1'b0);
      send_pixel("again_px", 8'd0, 7'd0, 16'hFFFE, 12'h456, 1'b0, 1'b1, 15'd0, 12'h456);

      // Reset while a winning pixel is in TEST: its write must never appear
      check("tst_t0_rdy", pixel_data_s_ready, 1);
      pixel_data_s_x     = 8'd7;
      pixel_data_s_y     = 7'd0;
      pixel_data_s_depth = 16'h0010;
      pixel_data_s_color = 12'hFFF;
      pixel_data_s_last  = 1'b1;
      pixel_data_s_valid = 1'b1;
      @(negedge clk);
      pixel_data_s_valid = 1'b0;
      check("tst_t1_rdy", pixel_data_s_ready, 0);
      apply_reset();
      check("tst_rst_data", fb_write_data, 0);
      run_clear("clr3", 1'b0);

      // Stored FFFE at (0,0) was wiped by the clear, so it wins again
      send_pixel("post_rst", 8'd0, 7'd0, 16'hFFFE, 12'h789, 1'b0, 1'b1, 15'd0, 12'h789);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
